// File: rtl/wb_rf_write_arbiter.sv
// Write-port arbiter for the GPR file: the pipeline WB result wins, late results queue in a FIFO and drain into idle slots.
// Optional STARVE_GUARD_EN: a one-cycle WB hold (Stall_Req) forces the queue head out when it has waited too long.
module wb_rf_write_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int DW           = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       WB_Wen,
  input  logic [4:0]                 WB_Dst,
  input  logic [DW-1:0]              WB_Result,
  input  logic                       Late_Valid,
  input  logic [4:0]                 Late_Dst,
  input  logic [DW-1:0]              Late_Data,
  output logic                       Late_Ready,
  input  logic                       Late_Flush,
  input  logic [4:0]                 Query_Rs,
  input  logic [4:0]                 Query_Rt,
  output logic                       Pend_Rs,
  output logic                       Pend_Rt,
  output logic                       Stall_Req,
  output logic                       RF_Wen,
  output logic [4:0]                 RF_Dst,
  output logic [DW-1:0]              RF_Data,
  output logic [$clog2(DEPTH+1)-1:0] Occupancy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    count;
  logic [DEPTH-1:0] ent_valid, ent_valid_next;
  logic [4:0]       ent_dst  [DEPTH];
  logic [DW-1:0]    ent_data [DEPTH];

  logic fifo_empty, head_valid, wb_grant, drain, pop, enq, enq_killed;

  // Late channel handshake: an entry transfers on a clock edge where Late_Valid && Late_Ready;
  // Late_Ready depends only on the registered count, so a pop in the same cycle does not open the FIFO.
  assign Late_Ready = !rst && (count < CW'(DEPTH));
  assign Occupancy  = count;

  assign fifo_empty = (count == '0);
  assign head_valid = !fifo_empty && ent_valid[rd_ptr];
  assign wb_grant   = !rst && !Stall_Req && WB_Wen && (WB_Dst != 5'd0);
  assign drain      = head_valid && (Stall_Req || !wb_grant);
  // Killed heads leave without consuming the write port.
  assign pop        = !fifo_empty && (!ent_valid[rd_ptr] || drain);
  assign enq        = Late_Valid && Late_Ready && (Late_Dst != 5'd0) && !Late_Flush;
  assign enq_killed = wb_grant && (Late_Dst == WB_Dst);

  always_comb begin
    RF_Wen  = 1'b0;
    RF_Dst  = 5'd0;
    RF_Data = '0;
    if (drain) begin
      RF_Wen  = 1'b1;
      RF_Dst  = ent_dst[rd_ptr];
      RF_Data = ent_data[rd_ptr];
    end else if (wb_grant) begin
      RF_Wen  = 1'b1;
      RF_Dst  = WB_Dst;
      RF_Data = WB_Result;
    end
  end

  always_comb begin
    Pend_Rs = 1'b0;
    Pend_Rt = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (Query_Rs != 5'd0) && (ent_dst[i] == Query_Rs)) Pend_Rs = 1'b1;
      if (ent_valid[i] && (Query_Rt != 5'd0) && (ent_dst[i] == Query_Rt)) Pend_Rt = 1'b1;
    end
  end

  // Newer pipeline write to D makes every queued write to D obsolete (last writer wins).
  always_comb begin
    ent_valid_next = ent_valid;
    for (int i = 0; i < DEPTH; i++) begin
      if (wb_grant && (ent_dst[i] == WB_Dst)) ent_valid_next[i] = 1'b0;
    end
    if (pop) ent_valid_next[rd_ptr] = 1'b0;
    if (enq) ent_valid_next[wr_ptr] = !enq_killed;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      ent_valid <= '0;
    end else if (Late_Flush) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      ent_valid <= '0;
    end else begin
      ent_valid <= ent_valid_next;
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (enq && !pop)      count <= count + CW'(1);
      else if (pop && !enq) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      ent_dst[wr_ptr]  <= Late_Dst;
      ent_data[wr_ptr] <= Late_Data;
    end
  end

`ifdef STARVE_GUARD_EN
  localparam int AW = $clog2(STARVE_LIMIT+1);
  logic [AW-1:0] age, age_next;
  logic          stall_q, stall_next;

  always_comb begin
    age_next = age;
    if (!head_valid || pop)             age_next = '0;
    else if (age < AW'(STARVE_LIMIT))   age_next = age + AW'(1);
    // The hold lands in the cycle the head has waited STARVE_LIMIT-1 cycles.
    stall_next = !stall_q && (age_next == AW'(STARVE_LIMIT-1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age     <= '0;
      stall_q <= 1'b0;
    end else if (Late_Flush) begin
      age     <= '0;
      stall_q <= 1'b0;
    end else begin
      age     <= age_next;
      stall_q <= stall_next;
    end
  end

  assign Stall_Req = stall_q;
`else
  assign Stall_Req = 1'b0;
`endif
endmodule

// File: doc/wb_rf_write_arbiter.md
Name: wb_rf_write_arbiter

Overview:
Owns the single GPR write port behind the WB stage and shares it between two writers. The in-order pipeline WB result has priority. The late-writeback channel (uncached loads and other multi-cycle results returning after their instruction left WB) is buffered in a small FIFO and drained into idle write slots. The block keeps last-writer-wins ordering, reports pending destinations to hazard logic, and can force a one-cycle WB hold so queued writes cannot starve.

Parameters:
DEPTH, 4, late-writeback FIFO entries (power of two, >=2)
STARVE_LIMIT, 8, cycles the FIFO head may wait before a forced drain
DW, 32, data width

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
WB_Wen  in  1  pipeline WB GPR write request (already gated by WB_DisWr)
WB_Dst  in  5  pipeline destination register
WB_Result  in  DW  pipeline write data
Late_Valid  in  1  late result valid
Late_Dst  in  5  late destination register
Late_Data  in  DW  late write data
Late_Ready  out  1  FIFO can accept an entry
Late_Flush  in  1  exception flush; discard all queued late results
Query_Rs  in  5  hazard query register A
Query_Rt  in  5  hazard query register B
Pend_Rs  out  1  valid queued entry targets Query_Rs
Pend_Rt  out  1  valid queued entry targets Query_Rt
Stall_Req  out  1  WB hold request; WB must re-present its write next cycle
RF_Wen  out  1  register-file write enable
RF_Dst  out  5  register-file write address
RF_Data  out  DW  register-file write data
Occupancy  out  $clog2(DEPTH+1)  queued entry count, including killed entries

Behaviour:
- Reset (async, active-high): FIFO empty, pointers/count/age = 0, Stall_Req=0, Late_Ready=0 while rst high. RF_Wen/Pend_* = 0.
- Late_Ready = !rst && (count < DEPTH), from registered count. Enqueue on Late_Valid && Late_Ready. Late_Dst==0 is accepted and dropped (no entry).
- Each entry holds {valid, dst, data}. Late results are always older than a concurrently retiring pipeline instruction; issue logic guarantees this.
- Write-port selection, combinational, zero latency:
  1) Stall_Req=1: head drains if valid; WB_Wen ignored.
  2) WB_Wen && WB_Dst!=0: pipeline writes. RF_Dst=WB_Dst, RF_Data=WB_Result.
  3) Otherwise a valid head drains.
- Killed head (valid=0) is popped in any cycle without using the port. At most one pop per cycle.
- WAW kill: when the pipeline write is granted with dst D, every queued entry with dst D is cleared to valid=0 at the clock edge. A same-cycle enqueue with Late_Dst==D is stored with valid=0.
- Enqueue and pop in the same cycle: count unchanged. Pointers wrap modulo DEPTH. A full FIFO with a pop does not raise Late_Ready that cycle.
- Pend_Rs/Pend_Rt: OR over valid entries with dst==query. Query 0 always returns 0. Registered state only; the incoming Late_* is not included.
- Late_Flush: at the next edge, count=0, all entries invalid, age=0, Stall_Req=0. Same-cycle enqueue is dropped. Same-cycle drain still writes, since it is combinational that cycle.
- Age counter: counts cycles while head is valid and not drained. Clears on head pop, flush, or empty. Saturates at STARVE_LIMIT.
- WB_Dst==0 writes never reach RF (RF_Wen=0 unless a drain takes the slot).

Optional Feature:
STARVE_GUARD_EN
- Defined: when age reaches STARVE_LIMIT-1 with a valid head still undrained, Stall_Req is registered high for exactly one cycle. That cycle drains the head and age clears. Stall_Req cannot re-assert within STARVE_LIMIT cycles.
- Undefined: Stall_Req tied 0, age counter absent. Drains happen only in idle pipeline slots.

Test Plan:
- Reset mid-traffic: rst pulsed while count=3 -> Occupancy=0, Late_Ready=0 during rst, RF_Wen=0, Pend_*=0; after release Late_Ready=1.
- Idle drain: Late enqueue r5=0x1234, WB_Wen=0 -> next cycle RF_Wen=1, RF_Dst=5, RF_Data=0x1234, Occupancy back to 0.
- Priority plus WAW: queue r7=0xAAAA, then WB_Wen=1 r7=0xBBBB -> RF writes 0xBBBB. Queued entry killed and popped with no write; Pend_Rt(query 7) drops to 0 after the edge.
- Full boundary: DEPTH=4, WB_Wen=1 with r1 every cycle, enqueue r2..r5 -> Late_Ready=0 after 4th. A 5th Late_Valid is held and not lost; accepted after first drain.
- Starvation (STARVE_GUARD_EN): one entry r9, WB_Wen=1 continuously with r3 -> Stall_Req pulses one cycle at age 7, r9 written that cycle, pipeline r3 write delayed one cycle.
- Flush: 2 entries queued, Late_Flush=1 with Late_Valid=1 -> next cycle Occupancy=0, no late write ever appears, incoming entry dropped.
